// File: rtl/mac_acc_pkg.sv
// Shared widths, FIFO entry layout, FSM states and the per-lane requantizer
// for the MAC result accumulator.
package mac_acc_pkg;

   localparam int COLUMN = 6;
   localparam int OW     = 22;
   localparam int AW     = 32;
   localparam int BW     = 16;
   localparam int SW     = 5;
   localparam int QW     = 8;
   localparam int DEPTH  = 32;
   localparam int MARGIN = 20;

   localparam int DW = COLUMN * OW;
   localparam int EW = DW + 2;
   localparam int CW = $clog2(DEPTH) + 1;

   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_ACC  = 2'd1,
      ST_HOLD = 2'd2
   } acc_state_t;

   typedef struct packed {
      logic          first;
      logic          last;
      logic [DW-1:0] data;
   } fifo_entry_t;

   localparam logic signed [AW:0] SAT_HI = (AW+1)'(2**(QW-1) - 1);
   localparam logic signed [AW:0] SAT_LO = (AW+1)'(-(2**(QW-1)));

   // Round half up, arithmetic shift, optional ReLU, saturate to QW bits.
   // One guard bit keeps the rounding add from wrapping near +2^(AW-1).
   function automatic logic signed [QW-1:0] requant(
      input logic signed [AW-1:0] acc,
      input logic        [SW-1:0] sh,
      input logic                 relu
   );
      logic signed [AW:0] v_rnd;
      logic signed [AW:0] v_sum;
      logic signed [AW:0] v_shr;
      v_rnd = '0;
      if (sh != '0)
         v_rnd = (AW+1)'(1) << (sh - 1'b1);
      v_sum = $signed({acc[AW-1], acc}) + v_rnd;
      v_shr = v_sum >>> sh;
      if (relu && v_shr[AW])
         v_shr = '0;
      if (v_shr > SAT_HI)
         return SAT_HI[QW-1:0];
      else if (v_shr < SAT_LO)
         return SAT_LO[QW-1:0];
      return v_shr[QW-1:0];
   endfunction

endpackage

// File: rtl/acc_skid_fifo.sv
// Skid FIFO for the MAC result stream. Pushes have no handshake: a push
// into a full FIFO without a simultaneous pop is dropped and flagged.
module acc_skid_fifo
   import mac_acc_pkg::*;
(
   input  logic          clk,
   input  logic          rst_n,
   input  logic          i_push,
   input  logic [EW-1:0] i_din,
   input  logic          i_pop,
   output logic [EW-1:0] o_dout,
   output logic [CW-1:0] o_count,
   output logic          o_full,
   output logic          o_empty,
   output logic          o_drop
);

   localparam int PW = CW - 1;

   logic [EW-1:0] r_mem [DEPTH];
   logic [PW-1:0] r_wr_ptr;
   logic [PW-1:0] r_rd_ptr;
   logic [CW-1:0] r_count;
   logic          w_do_push;
   logic          w_do_pop;

   assign o_full    = (r_count == CW'(DEPTH));
   assign o_empty   = (r_count == '0);
   assign w_do_pop  = i_pop && !o_empty;
   assign w_do_push = i_push && (!o_full || w_do_pop);
   assign o_drop    = i_push && !w_do_push;
   assign o_dout    = r_mem[r_rd_ptr];
   assign o_count   = r_count;

   // Pointer and occupancy tracking; reset empties the FIFO.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_wr_ptr <= '0;
         r_rd_ptr <= '0;
         r_count  <= '0;
      end else begin
         if (w_do_push)
            r_wr_ptr <= r_wr_ptr + PW'(1);
         if (w_do_pop)
            r_rd_ptr <= r_rd_ptr + PW'(1);
         case ({w_do_push, w_do_pop})
            2'b10:   r_count <= r_count + CW'(1);
            2'b01:   r_count <= r_count - CW'(1);
            default: ;
         endcase
      end
   end

   // Storage array; contents are don't-care until written.
   always_ff @(posedge clk) begin
      if (w_do_push)
         r_mem[r_wr_ptr] <= i_din;
   end

endmodule

// File: rtl/mac_acc_out.sv
// Accumulates MAC column partial sums over a first..last group, adds bias,
// requantizes and presents one vector per group on a valid/ready stream.
//
//   state   | meaning
//   --------+----------------------------------------------
//   IDLE    | no group open
//   ACC     | group open, partial sums accumulating
//   HOLD    | result pending on acc_s_* until accepted
module mac_acc_out
   import mac_acc_pkg::*;
(
   input  logic                 clk,
   input  logic                 rst_n,
   input  logic [COLUMN*OW-1:0] mac_s_data,
   input  logic                 mac_s_first,
   input  logic                 mac_s_last,
   input  logic                 mac_s_valid,
   output logic                 mac_s_ready,
   input  logic [COLUMN*BW-1:0] bias,
   input  logic [SW-1:0]        shift,
   input  logic                 relu_en,
   output logic [COLUMN*QW-1:0] acc_s_data,
   output logic                 acc_s_valid,
   input  logic                 acc_s_ready,
   output logic                 err_ovf,
   output logic                 err_seq
);

   acc_state_t           r_state;
   logic signed [AW-1:0] r_acc [COLUMN];
   logic [SW-1:0]        r_sh;
   logic                 r_relu;
   logic [COLUMN*QW-1:0] r_out;
   logic                 r_valid;
   logic                 r_ready;
   logic                 r_err_ovf;
   logic                 r_err_seq;

   fifo_entry_t          w_wr_entry;
   fifo_entry_t          w_rd_entry;
   logic [EW-1:0]        w_dout;
   logic [CW-1:0]        w_count;
   logic [CW-1:0]        w_count_next;
   logic                 w_full;
   logic                 w_empty;
   logic                 w_drop;
   logic                 w_pop;
   logic                 w_push_ok;
   logic                 w_accept;
   logic                 w_grp_beat;
   logic                 w_close;
   logic [SW-1:0]        w_sh_eff;
   logic                 w_relu_eff;
   logic signed [AW-1:0] w_acc_next [COLUMN];
   logic [COLUMN*QW-1:0] w_q;

   assign w_wr_entry = {mac_s_first, mac_s_last, mac_s_data};
   assign w_rd_entry = fifo_entry_t'(w_dout);

   acc_skid_fifo u_fifo (
      .clk     (clk),
      .rst_n   (rst_n),
      .i_push  (mac_s_valid),
      .i_din   (w_wr_entry),
      .i_pop   (w_pop),
      .o_dout  (w_dout),
      .o_count (w_count),
      .o_full  (w_full),
      .o_empty (w_empty),
      .o_drop  (w_drop)
   );

   // A stalled HOLD blocks popping so the pending result is not overwritten.
   assign w_pop      = !w_empty && !((r_state == ST_HOLD) && !acc_s_ready);
   assign w_accept   = (r_state == ST_HOLD) && acc_s_ready;
   assign w_push_ok  = mac_s_valid && (!w_full || w_pop);
   assign w_grp_beat = w_pop && (w_rd_entry.first || (r_state == ST_ACC));
   assign w_close    = w_grp_beat && w_rd_entry.last;

   // A single-beat group must use the live shift/relu, not the stale latch.
   assign w_sh_eff   = w_rd_entry.first ? shift   : r_sh;
   assign w_relu_eff = w_rd_entry.first ? relu_en : r_relu;

   // Occupancy after this edge, used for the registered ready.
   always_comb begin
      w_count_next = w_count;
      case ({w_push_ok, w_pop})
         2'b10:   w_count_next = w_count + CW'(1);
         2'b01:   w_count_next = w_count - CW'(1);
         default: ;
      endcase
   end

   // Per-lane next accumulator and its requantized value.
   always_comb begin
      w_q = '0;
      for (int j = 0; j < COLUMN; j++) begin
         w_acc_next[j] = (w_rd_entry.first ? AW'(signed'(bias[j*BW +: BW])) : r_acc[j])
                       + AW'(signed'(w_rd_entry.data[j*OW +: OW]));
         w_q[j*QW +: QW] = requant(w_acc_next[j], w_sh_eff, w_relu_eff);
      end
   end

   // Group FSM, accumulator lanes and registered result/valid.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_state   <= ST_IDLE;
         r_sh      <= '0;
         r_relu    <= 1'b0;
         r_out     <= '0;
         r_valid   <= 1'b0;
         r_err_seq <= 1'b0;
         for (int j = 0; j < COLUMN; j++)
            r_acc[j] <= '0;
      end else begin
         if (w_accept) begin
            r_state <= ST_IDLE;
            r_valid <= 1'b0;
         end
         if (w_pop) begin
            if (w_rd_entry.first) begin
               if (r_state == ST_ACC)
                  r_err_seq <= 1'b1;
               r_sh    <= shift;
               r_relu  <= relu_en;
               r_state <= ST_ACC;
            end else if (r_state != ST_ACC) begin
               r_err_seq <= 1'b1;
            end
            if (w_grp_beat) begin
               for (int j = 0; j < COLUMN; j++)
                  r_acc[j] <= w_acc_next[j];
            end
            if (w_close) begin
               r_state <= ST_HOLD;
               r_valid <= 1'b1;
               r_out   <= w_q;
            end
         end
      end
   end

   // Flow control back to the array and sticky overflow flag.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_ready   <= 1'b0;
         r_err_ovf <= 1'b0;
      end else begin
         r_ready <= (w_count_next < CW'(DEPTH - MARGIN));
         if (w_drop)
            r_err_ovf <= 1'b1;
      end
   end

   assign mac_s_ready = r_ready;
   assign acc_s_data  = r_out;
   assign acc_s_valid = r_valid;
   assign err_ovf     = r_err_ovf;
   assign err_seq     = r_err_seq;

endmodule

// File: tb/tb_mac_acc_out.sv
// Bench for mac_acc_out: directed groups plus random traffic, compared every
// cycle against a queue-based behavioural model of the accumulator.
module tb_mac_acc_out;
   import mac_acc_pkg::*;

   logic                 clk = 1'b0;
   logic                 rst_n = 1'b1;
   logic [DW-1:0]        mac_s_data = '0;
   logic                 mac_s_first = 1'b0;
   logic                 mac_s_last = 1'b0;
   logic                 mac_s_valid = 1'b0;
   logic                 mac_s_ready;
   logic [COLUMN*BW-1:0] bias = '0;
   logic [SW-1:0]        shift = '0;
   logic                 relu_en = 1'b0;
   logic [COLUMN*QW-1:0] acc_s_data;
   logic                 acc_s_valid;
   logic                 acc_s_ready = 1'b0;
   logic                 err_ovf;
   logic                 err_seq;

   always #5 clk = ~clk;

   mac_acc_out dut (
      .clk         (clk),
      .rst_n       (rst_n),
      .mac_s_data  (mac_s_data),
      .mac_s_first (mac_s_first),
      .mac_s_last  (mac_s_last),
      .mac_s_valid (mac_s_valid),
      .mac_s_ready (mac_s_ready),
      .bias        (bias),
      .shift       (shift),
      .relu_en     (relu_en),
      .acc_s_data  (acc_s_data),
      .acc_s_valid (acc_s_valid),
      .acc_s_ready (acc_s_ready),
      .err_ovf     (err_ovf),
      .err_seq     (err_seq)
   );

   int n_vec = 0;
   int n_err = 0;

   typedef struct {
      logic [DW-1:0] d;
      bit            f;
      bit            l;
   } beat_t;

   beat_t                q[$];
   bit                   m_open, m_pend, m_ready, m_ovf, m_seq, m_relu;
   int                   m_acc [COLUMN];
   int                   m_sh;
   logic [COLUMN*QW-1:0] m_out;

   task automatic chk(input string tag, input logic signed [63:0] obs, input logic signed [63:0] exp);
      n_vec++;
      if (obs !== exp) begin
         n_err++;
         $display("FAIL %s: got %0d, expected %0d", tag, obs, exp);
      end
   endtask

   function automatic int lane_of(input logic [DW-1:0] d, input int j);
      return int'($signed(d[j*OW +: OW]));
   endfunction

   function automatic int bias_of(input int j);
      return int'($signed(bias[j*BW +: BW]));
   endfunction

   function automatic longint ref_q(input longint acc, input int sh, input bit relu);
      longint r;
      r = acc;
      if (sh > 0)
         r = r + (longint'(1) << (sh - 1));
      r = r >>> sh;
      if (relu && r < 0) r = 0;
      if (r > 127)  r = 127;
      if (r < -128) r = -128;
      return r;
   endfunction

   task automatic model_reset();
      q.delete();
      m_open = 0; m_pend = 0; m_ready = 0; m_ovf = 0; m_seq = 0;
      m_relu = 0; m_sh = 0; m_out = '0;
      for (int j = 0; j < COLUMN; j++) m_acc[j] = 0;
   endtask

   // One clock of the reference behaviour, using the inputs seen at the edge.
   task automatic model_step();
      bit    pop, taken;
      beat_t b;
      pop = (q.size() > 0) && !(m_pend && !acc_s_ready);
      if (m_pend && acc_s_ready) m_pend = 0;
      if (pop) begin
         b = q.pop_front();
         taken = 0;
         if (b.f) begin
            if (m_open) m_seq = 1;
            for (int j = 0; j < COLUMN; j++) m_acc[j] = bias_of(j) + lane_of(b.d, j);
            m_sh = int'(shift);
            m_relu = relu_en;
            m_open = 1;
            taken = 1;
         end else if (m_open) begin
            for (int j = 0; j < COLUMN; j++) m_acc[j] = m_acc[j] + lane_of(b.d, j);
            taken = 1;
         end else begin
            m_seq = 1;
         end
         if (taken && b.l) begin
            m_open = 0;
            m_pend = 1;
            for (int j = 0; j < COLUMN; j++)
               m_out[j*QW +: QW] = QW'(ref_q(longint'(m_acc[j]), m_sh, m_relu));
         end
      end
      if (mac_s_valid) begin
         if (q.size() < DEPTH) begin
            b.d = mac_s_data; b.f = mac_s_first; b.l = mac_s_last;
            q.push_back(b);
         end else begin
            m_ovf = 1;
         end
      end
      m_ready = (q.size() < DEPTH - MARGIN);
   endtask

   task automatic step();
      @(posedge clk);
      model_step();
      #1;
      chk("valid", acc_s_valid, m_pend);
      chk("mac_ready", mac_s_ready, m_ready);
      chk("err_ovf", err_ovf, m_ovf);
      chk("err_seq", err_seq, m_seq);
      chk("data", acc_s_data, m_out);
   endtask

   task automatic do_reset();
      mac_s_valid = 0;
      rst_n = 0;
      #1;
      model_reset();
      chk("rst_valid", acc_s_valid, 0);
      chk("rst_data", acc_s_data, 0);
      chk("rst_ready", mac_s_ready, 0);
      chk("rst_ovf", err_ovf, 0);
      chk("rst_seq", err_seq, 0);
      @(negedge clk);
      rst_n = 1;
   endtask

   function automatic logic [DW-1:0] mk(input int l0, input int l1);
      logic [DW-1:0] d;
      for (int j = 0; j < COLUMN; j++) d[j*OW +: OW] = OW'(int'($urandom_range(0, 4000)) - 2000);
      d[OW-1:0] = OW'(l0);
      d[2*OW-1:OW] = OW'(l1);
      return d;
   endfunction

   function automatic int rnd_small();
      return int'($urandom_range(0, 2000)) - 1000;
   endfunction

   task automatic set_bias(input int b0, input int b1);
      for (int j = 0; j < COLUMN; j++) bias[j*BW +: BW] = BW'(int'($urandom_range(0, 200)) - 100);
      bias[BW-1:0] = BW'(b0);
      bias[2*BW-1:BW] = BW'(b1);
   endtask

   task automatic send(input logic [DW-1:0] d, input bit f, input bit l);
      mac_s_valid = 1; mac_s_data = d; mac_s_first = f; mac_s_last = l;
      step();
      mac_s_valid = 0;
   endtask

   task automatic wait_valid();
      for (int i = 0; i < 40 && !acc_s_valid; i++) step();
      chk("wait_valid", acc_s_valid, 1);
   endtask

   task automatic idle(input int n);
      mac_s_valid = 0;
      for (int i = 0; i < n; i++) step();
   endtask

   initial begin
      int n_out;
      #2;
      do_reset();
      idle(2);

      // multi-beat group with rounding shift
      acc_s_ready = 1;
      set_bias(10, rnd_small());
      shift = 5'd2; relu_en = 0;
      send(mk(100, rnd_small()), 1, 0);
      send(mk(200, rnd_small()), 0, 0);
      send(mk(-50, rnd_small()), 0, 1);
      wait_valid();
      chk("t1_lane0", $signed(acc_s_data[QW-1:0]), 65);
      idle(3);

      // saturation both ways on a single-beat group
      set_bias(0, 0);
      shift = 5'd0;
      send(mk(1000, -1000), 1, 1);
      wait_valid();
      chk("sat_hi", $signed(acc_s_data[QW-1:0]), 127);
      chk("sat_lo", $signed(acc_s_data[2*QW-1:QW]), -128);
      idle(3);

      // relu and round-half-up
      relu_en = 1;
      send(mk(-40, rnd_small()), 1, 1);
      wait_valid();
      chk("relu_on", $signed(acc_s_data[QW-1:0]), 0);
      idle(3);
      relu_en = 0;
      send(mk(-40, rnd_small()), 1, 1);
      wait_valid();
      chk("relu_off", $signed(acc_s_data[QW-1:0]), -40);
      idle(3);
      shift = 5'd1;
      send(mk(7, rnd_small()), 1, 1);
      wait_valid();
      chk("round_half", $signed(acc_s_data[QW-1:0]), 4);
      idle(3);

      // backpressure: fill the FIFO, then overflow by one beat
      do_reset();
      acc_s_ready = 0;
      shift = 5'd3;
      set_bias(rnd_small(), rnd_small());
      for (int i = 0; i < 34; i++) send(mk(rnd_small(), rnd_small()), (i % 2) == 0, (i % 2) == 1);
      chk("ovf_before", err_ovf, 0);
      chk("ready_low", mac_s_ready, 0);
      send(mk(rnd_small(), rnd_small()), 1, 0);
      chk("ovf_after", err_ovf, 1);
      acc_s_ready = 1;
      n_out = 0;
      for (int i = 0; i < 80; i++) begin
         if (acc_s_valid) n_out++;
         step();
      end
      chk("groups_out", n_out, 17);

      // first, mid, first, last: only the second group survives
      do_reset();
      acc_s_ready = 1;
      set_bias(10, rnd_small());
      shift = 5'd0; relu_en = 0;
      send(mk(100, rnd_small()), 1, 0);
      send(mk(100, rnd_small()), 0, 0);
      send(mk(5, rnd_small()), 1, 0);
      send(mk(6, rnd_small()), 0, 1);
      wait_valid();
      chk("seq_err", err_seq, 1);
      chk("seq_lane0", $signed(acc_s_data[QW-1:0]), 21);
      n_out = 0;
      for (int i = 0; i < 6; i++) begin
         step();
         if (acc_s_valid) n_out++;
      end
      chk("seq_one_out", n_out, 0);

      // reset in the middle of a group
      send(mk(300, rnd_small()), 1, 0);
      send(mk(300, rnd_small()), 0, 0);
      do_reset();
      set_bias(3, rnd_small());
      send(mk(50, rnd_small()), 1, 1);
      wait_valid();
      chk("post_rst", $signed(acc_s_data[QW-1:0]), 53);
      idle(3);

      // random traffic
      do_reset();
      for (int i = 0; i < 400; i++) begin
         mac_s_valid = mac_s_ready ? ($urandom_range(0, 3) != 0) : ($urandom_range(0, 7) == 0);
         for (int j = 0; j < COLUMN; j++) begin
            mac_s_data[j*OW +: OW] = OW'($urandom);
            bias[j*BW +: BW] = BW'($urandom);
         end
         mac_s_first = ($urandom_range(0, 3) == 0);
         mac_s_last  = ($urandom_range(0, 2) == 0);
         if ($urandom_range(0, 15) == 0) shift = SW'($urandom);
         if ($urandom_range(0, 15) == 0) relu_en = ~relu_en;
         acc_s_ready = ($urandom_range(0, 2) != 0);
         step();
      end
      acc_s_ready = 1;
      idle(60);

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule
